instr_encoder: RTL and testbench

//  Encodes the instruction classes handled by controlUnit (add, addi, lw, sw, beq, bne) from fields into 32-bit MIPS words.

---
 rtl/instr_encoder.sv | 136 +++++++++++++
 tb/tb_instr_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Encodes add/addi/lw/sw/beq/bne fields into 32-bit MIPS words
//               and queues them in a first-word-fall-through FIFO, each word
//               tagged with its instruction-memory word address.
//               Optional macro ENC_ZERO_DEST_CHECK_EN drops add/addi/lw that
//               target register 0.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_kind,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic [15:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     err_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                  c_PTR_W = $clog2(DEPTH);
    localparam int                  c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0]   c_BASE  = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] c_K_ADD  = 3'd0;
    localparam logic [2:0] c_K_ADDI = 3'd1;
    localparam logic [2:0] c_K_LW   = 3'd2;
    localparam logic [2:0] c_K_SW   = 3'd3;
    localparam logic [2:0] c_K_BEQ  = 3'd4;
    localparam logic [2:0] c_K_BNE  = 3'd5;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;

    logic [31:0]        r_mem_instr [DEPTH];
    logic [ADDR_W-1:0]  r_mem_addr  [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_err;

    logic               w_kind_ok;
    logic               w_zero_dest;
    logic               w_legal;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_instr;

    // Unused fields never reach the word: each kind selects only its own fields.
    always_comb begin
        w_kind_ok = 1'b1;
        w_instr   = 32'd0;
        case (in_kind)
            c_K_ADD:  w_instr = {c_OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, c_FN_ADD};
            c_K_ADDI: w_instr = {c_OP_ADDI, in_rs, in_rt, in_imm};
            c_K_LW:   w_instr = {c_OP_LW,   in_rs, in_rt, in_imm};
            c_K_SW:   w_instr = {c_OP_SW,   in_rs, in_rt, in_imm};
            c_K_BEQ:  w_instr = {c_OP_BEQ,  in_rs, in_rt, in_imm};
            c_K_BNE:  w_instr = {c_OP_BNE,  in_rs, in_rt, in_imm};
            default:  w_kind_ok = 1'b0;
        endcase
    end

`ifdef ENC_ZERO_DEST_CHECK_EN
    assign w_zero_dest = ((in_kind == c_K_ADD) && (in_rd == 5'd0)) ||
                         (((in_kind == c_K_ADDI) || (in_kind == c_K_LW)) && (in_rt == 5'd0));
`else
    assign w_zero_dest = 1'b0;
`endif

    assign w_legal   = w_kind_ok & ~w_zero_dest;
    assign in_ready  = (r_count < c_FULL);
    assign out_valid = (r_count != '0);
    assign w_accept  = in_valid & in_ready;
    assign w_push    = w_accept & w_legal;
    assign w_pop     = out_valid & out_ready;

    // Storage needs no reset: the head is gated by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= w_instr;
            r_mem_addr[r_wr_ptr]  <= r_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= c_BASE;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_legal;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                r_addr   <= r_addr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_instr   = out_valid ? r_mem_instr[r_rd_ptr] : 32'd0;
    assign out_addr    = out_valid ? r_mem_addr[r_rd_ptr]  : '0;
    assign err_illegal = r_err;
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder: vector table, corner
//               sequences and random traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_illegal;
    logic [$clog2(DEPTH):0] count;

    instr_encoder #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .err_illegal (err_illegal),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          addr;
    } entry_t;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    entry_t q[$];
    int     m_addr;
    bit     m_err;
    int     n_chk  = 0;
    int     n_pass = 0;
    vec_t   tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit ref_legal(input int kind, input int rt, input int rd);
        if (kind > 5) return 1'b0;
`ifdef ENC_ZERO_DEST_CHECK_EN
        if (kind == 0 && rd == 0) return 1'b0;
        if ((kind == 1 || kind == 2) && rt == 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_enc(input int kind, input int rs, input int rt,
                                            input int rd, input int imm);
        int op;
        case (kind)
            1: op = 'h08;
            2: op = 'h23;
            3: op = 'h2B;
            4: op = 'h04;
            5: op = 'h05;
            default: op = 0;
        endcase
        if (kind == 0) return 32'(rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + 32);
        return 32'(op * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm);
    endfunction

    task automatic check_outputs();
        chk("count",       32'(count),       32'(q.size()));
        chk("out_valid",   32'(out_valid),   32'(q.size() > 0));
        chk("in_ready",    32'(in_ready),    32'(q.size() < DEPTH));
        chk("out_instr",   out_instr,        (q.size() > 0) ? q[0].instr : 32'd0);
        chk("out_addr",    32'(out_addr),    (q.size() > 0) ? 32'(q[0].addr) : 32'd0);
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
    endtask

    // One clock: model applies the pre-edge inputs, then outputs are compared.
    task automatic step();
        int  sz;
        bit  acc;
        sz = q.size();
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_addr = BASE_ADDR;
            m_err  = 1'b0;
        end else begin
            acc = in_valid && (sz < DEPTH);
            if (sz > 0 && out_ready) void'(q.pop_front());
            m_err = acc && !ref_legal(in_kind, in_rt, in_rd);
            if (acc && ref_legal(in_kind, in_rt, in_rd)) begin
                q.push_back('{ref_enc(in_kind, in_rs, in_rt, in_rd, in_imm), m_addr});
                m_addr = (m_addr + 1) % (1 << ADDR_W);
            end
        end
        check_outputs();
    endtask

    task automatic drive(input int kind, input int rs, input int rt, input int rd, input int imm);
        in_valid = 1'b1;
        in_kind  = 3'(kind);
        in_rs    = 5'(rs);
        in_rt    = 5'(rt);
        in_rd    = 5'(rd);
        in_imm   = 16'(imm);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  16'h0000, 32'h00221820};
        tbl[1] = '{3'd4, 5'd1,  5'd2,  5'd0,  16'hFFFF, 32'h1022FFFF};
        tbl[2] = '{3'd2, 5'd29, 5'd8,  5'd0,  16'h0004, 32'h8FA80004};
        tbl[3] = '{3'd3, 5'd29, 5'd9,  5'd0,  16'h0008, 32'hAFA90008};
        tbl[4] = '{3'd1, 5'd0,  5'd5,  5'd0,  16'h0007, 32'h20050007};
        tbl[5] = '{3'd0, 5'd31, 5'd31, 5'd31, 16'hFFFF, 32'h03FFF820};
        tbl[6] = '{3'd5, 5'd3,  5'd4,  5'd31, 16'h0010, 32'h14640010};
        tbl[7] = '{3'd1, 5'd7,  5'd1,  5'd31, 16'h8000, 32'h20E18000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
        m_addr = BASE_ADDR; m_err = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Vector table: one push, compare head word, then drain.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].kind, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm);
            out_ready = 1'b0;
            step();
            chk($sformatf("vec%0d_instr", i), out_instr, tbl[i].exp);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            step();
        end

        // Fill with out_ready low; the fifth request is held until a pop.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(0, i + 1, 2, 3, 0);
            step();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        chk("ready_after_pop", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        step();
        chk("held_accepted_count", 32'(count), 32'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        // Illegal kinds back to back, then a legal push.
        out_ready = 1'b0;
        drive(6, 1, 2, 3, 4);
        step();
        chk("illegal6_pulse", 32'(err_illegal), 32'd1);
        drive(7, 1, 2, 3, 4);
        step();
        chk("illegal7_pulse", 32'(err_illegal), 32'd1);
        drive(0, 4, 5, 0, 0);
        step();
        drive(3, 4, 5, 6, 9);
        step();
        in_valid = 1'b0;
        step();
        chk("illegal_pulse_ends", 32'(err_illegal), 32'd0);
        out_ready = 1'b1;
        repeat (3) step();

        // Address wrap: push continuously while draining.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(4, i, i + 1, 0, i);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();

        // Reset with entries buffered discards them.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(5, i, 7, 0, 100 + i);
            step();
        end
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        repeat (2) step();
        drive(2, 3, 4, 0, 12);
        step();
        chk("post_rst_addr", 32'(out_addr), 32'(BASE_ADDR));
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            in_kind   = 3'($urandom_range(0, 7));
            in_rs     = 5'($urandom);
            in_rt     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            in_rd     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            in_imm    = 16'($urandom);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
